versatile_mem_ctrl_wb_packer: RTL

- Per-port Wishbone B3 slave front end for the memory controller.
- Converts Wishbone classic and burst cycles into a packed 36-bit header/data word stream for the egress FIFO write side.
- Returns read data from the ingress FIFO read side.
- Each burst is fixed-length, so the SDRAM side always knows how many words to move; the block pads short writes and drains short reads to honour that length.

---
 rtl/versatile_mem_ctrl_wb_packer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/versatile_mem_ctrl_wb_packer.sv
// Wishbone B3 slave front end: packs classic/burst cycles into 36-bit egress words
// and returns read data from the ingress FIFO. VMC_PACKER_ADR_CHECK_EN enables address checking.
module versatile_mem_ctrl_wb_packer #(
    parameter int ADR_WIDTH  = 30,
    parameter int LINEAR_LEN = 8
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [ADR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [35:0]          egr_dat_o,
    output logic                 egr_we_o,
    input  logic                 egr_full_i,
    input  logic [31:0]          igr_dat_i,
    output logic                 igr_rd_o,
    input  logic                 igr_empty_i
);

    typedef enum logic [2:0] {IDLE, WR, PAD, RD, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [4:0]             words_left, words_left_nxt;
    logic [ADR_WIDTH-1:0]   exp_adr, exp_adr_nxt;
    logic [1:0]             bte_q, bte_nxt;
    logic [4:0]             burst_len;
    logic                   req;
    logic                   adr_ok;
    logic                   short_end;

    function automatic logic [ADR_WIDTH-1:0] adr_advance(input logic [ADR_WIDTH-1:0] adr,
                                                         input logic [1:0] bte);
        logic [ADR_WIDTH-1:0] mask;
        case (bte)
            2'b01:   mask = ADR_WIDTH'(3);
            2'b10:   mask = ADR_WIDTH'(7);
            2'b11:   mask = ADR_WIDTH'(15);
            default: mask = '1;
        endcase
        return (adr & ~mask) | ((adr + ADR_WIDTH'(1)) & mask);
    endfunction

    always_comb begin
        burst_len = 5'd1;
        if (wb_cti_i == 3'b010) begin
            case (wb_bte_i)
                2'b00:   burst_len = 5'(LINEAR_LEN);
                2'b01:   burst_len = 5'd4;
                2'b10:   burst_len = 5'd8;
                default: burst_len = 5'd16;
            endcase
        end
    end

    assign req       = wb_cyc_i & wb_stb_i;
    assign short_end = (wb_cti_i == 3'b111) || (wb_cti_i == 3'b000);
    assign wb_dat_o  = igr_dat_i;

`ifdef VMC_PACKER_ADR_CHECK_EN
    assign adr_ok = (wb_adr_i == exp_adr);
`else
    assign adr_ok = 1'b1;
`endif

    always_comb begin
        state_nxt      = state;
        words_left_nxt = words_left;
        exp_adr_nxt    = exp_adr;
        bte_nxt        = bte_q;
        wb_ack_o       = 1'b0;
        egr_we_o       = 1'b0;
        egr_dat_o      = '0;
        igr_rd_o       = 1'b0;
        case (state)
            IDLE: begin
                egr_dat_o = 36'({wb_adr_i, wb_we_i, wb_bte_i, wb_cti_i});
                if (req && !egr_full_i) begin
                    egr_we_o       = 1'b1;
                    words_left_nxt = burst_len;
                    exp_adr_nxt    = wb_adr_i;
                    bte_nxt        = wb_bte_i;
                    state_nxt      = wb_we_i ? WR : RD;
                end
            end
            WR: begin
                egr_dat_o = {wb_sel_i, wb_dat_i};
                if (!wb_cyc_i || (wb_stb_i && !adr_ok)) begin
                    state_nxt = PAD;
                end else if (wb_stb_i && !egr_full_i) begin
                    wb_ack_o       = 1'b1;
                    egr_we_o       = 1'b1;
                    words_left_nxt = words_left - 5'd1;
                    exp_adr_nxt    = adr_advance(exp_adr, bte_q);
                    if (words_left == 5'd1) state_nxt = IDLE;
                    else if (short_end)     state_nxt = PAD;
                end
            end
            PAD: begin
                if (!egr_full_i) begin
                    egr_we_o       = 1'b1;
                    words_left_nxt = words_left - 5'd1;
                    if (words_left == 5'd1) state_nxt = IDLE;
                end
            end
            RD: begin
                if (!wb_cyc_i || (wb_stb_i && !adr_ok)) begin
                    state_nxt = DRAIN;
                end else if (wb_stb_i && !igr_empty_i) begin
                    wb_ack_o       = 1'b1;
                    igr_rd_o       = 1'b1;
                    words_left_nxt = words_left - 5'd1;
                    exp_adr_nxt    = adr_advance(exp_adr, bte_q);
                    if (words_left == 5'd1) state_nxt = IDLE;
                    else if (short_end)     state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!igr_empty_i) begin
                    igr_rd_o       = 1'b1;
                    words_left_nxt = words_left - 5'd1;
                    if (words_left == 5'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= IDLE;
            words_left <= '0;
            exp_adr    <= '0;
            bte_q      <= '0;
        end else begin
            state      <= state_nxt;
            words_left <= words_left_nxt;
            exp_adr    <= exp_adr_nxt;
            bte_q      <= bte_nxt;
        end
    end

endmodule
